// File: rtl/line_burst_adapter_pkg.sv
// -----------------------------------------------------------------------------
// line_burst_adapter_pkg
// Shared definitions for the line/word burst adapter between L2 and main memory.
//   - Message codes on the L2 side and the memory side. Both sides use the same
//     numeric codes, and cache_hierarchy and main_memory use these constants too.
//   - FSM state encoding of the adapter.
//   - Default geometry plus the derived words-per-line and line width.
// -----------------------------------------------------------------------------
package line_burst_adapter_pkg;

    // Default geometry (the top module takes these as parameter defaults)
    localparam int DATA_WIDTH_DEF   = 32;
    localparam int ADDRESS_BITS_DEF = 32;
    localparam int MSG_BITS_DEF     = 4;
    localparam int OFFSET_BITS_DEF  = 2;
    localparam int N_DEF            = 1 << OFFSET_BITS_DEF;
    localparam int LINE_WIDTH_DEF   = DATA_WIDTH_DEF * N_DEF;

    // L2 <-> adapter message codes
    localparam logic [MSG_BITS_DEF-1:0] NO_REQ    = 4'd0;
    localparam logic [MSG_BITS_DEF-1:0] R_REQ     = 4'd1;
    localparam logic [MSG_BITS_DEF-1:0] WB_REQ    = 4'd2;
    localparam logic [MSG_BITS_DEF-1:0] MEM_RESP  = 4'd3;
    localparam logic [MSG_BITS_DEF-1:0] WB_ACK    = 4'd4;

    // adapter <-> memory message codes
    localparam logic [MSG_BITS_DEF-1:0] MEM_NOP   = 4'd0;
    localparam logic [MSG_BITS_DEF-1:0] MEM_READ  = 4'd1;
    localparam logic [MSG_BITS_DEF-1:0] MEM_WRITE = 4'd2;
    localparam logic [MSG_BITS_DEF-1:0] MEM_RDATA = 4'd3;
    localparam logic [MSG_BITS_DEF-1:0] MEM_WACK  = 4'd4;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

endpackage : line_burst_adapter_pkg

// File: rtl/line_burst_adapter_line_word_buffer.sv
// -----------------------------------------------------------------------------
// line_word_buffer
// N x DATA_WIDTH register file holding one cache line as individual words.
// Ports:
//   clk_i        clock, rising-edge
//   clr_i        synchronous clear of every word (highest priority)
//   load_en_i    parallel load of the whole line from load_line_i
//   load_line_i  line to load; word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_en_i      single-word write of wr_data_i into slot wr_idx_i
//   wr_idx_i     word slot for the single-word write
//   wr_data_i    word to write
//   rd_idx_i     word slot presented on rd_data_o
//   rd_data_o    word at rd_idx_i (combinational view of the registers)
//   line_o       whole line (combinational view of the registers)
// -----------------------------------------------------------------------------
module line_word_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 2,
    parameter int N          = 1 << IDX_BITS
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    load_en_i,
    input  logic [DATA_WIDTH*N-1:0] load_line_i,
    input  logic                    wr_en_i,
    input  logic [IDX_BITS-1:0]     wr_idx_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [IDX_BITS-1:0]     rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [DATA_WIDTH*N-1:0] line_o
);

    // Packed so the flattened line view needs no reshaping logic
    logic [N-1:0][DATA_WIDTH-1:0] word_q;

    // Word storage: clear beats line load beats single-word write
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            word_q <= '0;
        end else if (load_en_i) begin
            word_q <= load_line_i;
        end else if (wr_en_i) begin
            word_q[wr_idx_i] <= wr_data_i;
        end else begin
            word_q <= word_q;
        end
    end

    // Read views of the stored line
    always_comb begin
        rd_data_o = word_q[rd_idx_i];
        line_o    = word_q;
    end

endmodule : line_word_buffer

// File: rtl/line_burst_adapter.sv
// -----------------------------------------------------------------------------
// line_burst_adapter
// Turns one line-wide L2 request (fill read or write-back) into a burst of
// single-word memory transactions, and for reads gathers the returned words
// into one line-wide response. Neither side ever sees the other's data width.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cache2adapter_msg/address/data   L2 request (NO_REQ, R_REQ, WB_REQ)
//   adapter2cache_msg/address/data   response to L2 (MEM_RESP, WB_ACK), one cycle
//   adapter2mem_msg/address/data     word request to memory (MEM_READ, MEM_WRITE)
//   mem2adapter_msg/address/data     memory reply (MEM_RDATA, MEM_WACK)
//   busy                         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module line_burst_adapter
    import line_burst_adapter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int MSG_BITS     = MSG_BITS_DEF,
    parameter int OFFSET_BITS  = OFFSET_BITS_DEF
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [MSG_BITS-1:0]                    cache2adapter_msg,
    input  logic [ADDRESS_BITS-1:0]                cache2adapter_address,
    input  logic [DATA_WIDTH*(1<<OFFSET_BITS)-1:0] cache2adapter_data,
    output logic [MSG_BITS-1:0]                    adapter2cache_msg,
    output logic [ADDRESS_BITS-1:0]                adapter2cache_address,
    output logic [DATA_WIDTH*(1<<OFFSET_BITS)-1:0] adapter2cache_data,
    output logic [MSG_BITS-1:0]                    adapter2mem_msg,
    output logic [ADDRESS_BITS-1:0]                adapter2mem_address,
    output logic [DATA_WIDTH-1:0]                  adapter2mem_data,
    input  logic [MSG_BITS-1:0]                    mem2adapter_msg,
    input  logic [ADDRESS_BITS-1:0]                mem2adapter_address,
    input  logic [DATA_WIDTH-1:0]                  mem2adapter_data,
    output logic                                   busy
);

    localparam int N          = 1 << OFFSET_BITS;
    localparam int LINE_WIDTH = DATA_WIDTH * N;

    // Index of the last word in a line; the word counter stops here
    localparam logic [OFFSET_BITS-1:0] K_LAST = OFFSET_BITS'(N - 1);

    // Message codes resized to the configured message width
    localparam logic [MSG_BITS-1:0] C_R_REQ     = MSG_BITS'(R_REQ);
    localparam logic [MSG_BITS-1:0] C_WB_REQ    = MSG_BITS'(WB_REQ);
    localparam logic [MSG_BITS-1:0] C_MEM_RESP  = MSG_BITS'(MEM_RESP);
    localparam logic [MSG_BITS-1:0] C_WB_ACK    = MSG_BITS'(WB_ACK);
    localparam logic [MSG_BITS-1:0] C_MEM_READ  = MSG_BITS'(MEM_READ);
    localparam logic [MSG_BITS-1:0] C_MEM_WRITE = MSG_BITS'(MEM_WRITE);
    localparam logic [MSG_BITS-1:0] C_MEM_RDATA = MSG_BITS'(MEM_RDATA);
    localparam logic [MSG_BITS-1:0] C_MEM_WACK  = MSG_BITS'(MEM_WACK);

    // FSM and burst bookkeeping
    logic [2:0]              state_q,   state_d;
    logic [OFFSET_BITS-1:0]  k_q,       k_d;
    logic [ADDRESS_BITS-1:0] base_q,    base_d;
    logic                    is_read_q, is_read_d;   // selects MEM_RESP vs WB_ACK

    // Buffer control and views
    logic                    buf_load_s;
    logic                    buf_wr_s;
    logic [DATA_WIDTH-1:0]   buf_rd_data_s;
    logic [LINE_WIDTH-1:0]   buf_line_s;

    // Current word address; base has zero offset bits, so this never leaves the line
    logic [ADDRESS_BITS-1:0] word_addr_s;
    logic                    rd_reply_ok_s;
    logic                    wr_reply_ok_s;

    // Offset bits of the request address are deliberately discarded
    logic                    unused_offset_s;

    // Line buffer: cleared by reset, loaded on write-back accept, filled word by word on reads
    line_word_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_BITS   (OFFSET_BITS),
        .N          (N)
    ) u_buffer (
        .clk_i       (clock),
        .clr_i       (reset),
        .load_en_i   (buf_load_s),
        .load_line_i (cache2adapter_data),
        .wr_en_i     (buf_wr_s),
        .wr_idx_i    (k_q),
        .wr_data_i   (mem2adapter_data),
        .rd_idx_i    (k_q),
        .rd_data_o   (buf_rd_data_s),
        .line_o      (buf_line_s)
    );

    // Word address and reply qualification for the current burst slot
    always_comb begin
        unused_offset_s = ^cache2adapter_address[OFFSET_BITS-1:0];
        word_addr_s     = base_q + ADDRESS_BITS'(k_q);
        rd_reply_ok_s   = (mem2adapter_msg == C_MEM_RDATA) &&
                          (mem2adapter_address == word_addr_s);
        wr_reply_ok_s   = (mem2adapter_msg == C_MEM_WACK) &&
                          (mem2adapter_address == word_addr_s);
    end

    // Next-state logic for the burst FSM
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        is_read_d  = is_read_q;
        buf_load_s = 1'b0;
        buf_wr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cache2adapter_msg == C_R_REQ) begin
                    base_d    = {cache2adapter_address[ADDRESS_BITS-1:OFFSET_BITS],
                                 {OFFSET_BITS{1'b0}}};
                    k_d       = '0;
                    is_read_d = 1'b1;
                    state_d   = ST_RD_ISSUE;
                end else if (cache2adapter_msg == C_WB_REQ) begin
                    base_d     = {cache2adapter_address[ADDRESS_BITS-1:OFFSET_BITS],
                                  {OFFSET_BITS{1'b0}}};
                    k_d        = '0;
                    is_read_d  = 1'b0;
                    buf_load_s = 1'b1;
                    state_d    = ST_WR_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Stray replies (wrong address or code) leave the FSM waiting
                if (rd_reply_ok_s) begin
                    buf_wr_s = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = ST_RESP;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_ISSUE: begin
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (wr_reply_ok_s) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_RESP;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_WR_ISSUE;
                    end
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any burst in flight without responding
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            base_q    <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            is_read_q <= is_read_d;
        end
    end

    // Output decode from registered state only, so outputs are glitch-free per state
    always_comb begin
        adapter2cache_msg     = '0;
        adapter2cache_address = '0;
        adapter2cache_data    = '0;
        adapter2mem_msg       = '0;
        adapter2mem_address   = '0;
        adapter2mem_data      = '0;
        busy                  = (state_q != ST_IDLE);
        case (state_q)
            ST_RD_ISSUE: begin
                adapter2mem_msg     = C_MEM_READ;
                adapter2mem_address = word_addr_s;
            end
            ST_WR_ISSUE: begin
                adapter2mem_msg     = C_MEM_WRITE;
                adapter2mem_address = word_addr_s;
                adapter2mem_data    = buf_rd_data_s;
            end
            ST_RESP: begin
                adapter2cache_address = base_q;
                if (is_read_q) begin
                    adapter2cache_msg  = C_MEM_RESP;
                    adapter2cache_data = buf_line_s;
                end else begin
                    adapter2cache_msg  = C_WB_ACK;
                    adapter2cache_data = '0;
                end
            end
            default: begin
                adapter2cache_msg = '0;
            end
        endcase
    end

endmodule : line_burst_adapter
